uart_rx_timing_counter: RTL and testbench
=========================================

UART_RX_TIMING_COUNTER -- requirements
Module: uart_rx_timing_counter

Interface
REQ-001 Parameter PRESCALE_W, 6: width of prescale and edge_count.
REQ-002 Parameter BIT_CNT_W, 4: width of frame_bits and bit_count.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port prescale  input  PRESCALE_W  oversampling ratio P (clocks per bit).
REQ-006 Port frame_bits  input  BIT_CNT_W  bits per frame F (start + data + parity + stop).
REQ-007 Port counter_enable  input  1  level request to time a frame.
REQ-008 Port edge_count  output  PRESCALE_W  clock index within the current bit.
REQ-009 Port bit_count  output  BIT_CNT_W  bit index within the current frame.
REQ-010 Port sample_strobe  output  1  mid-bit sampling pulse(s).
REQ-011 Port bit_done  output  1  pulse on the last clock of each bit.
REQ-012 Port frame_done  output  1  pulse on the last clock of the frame.
REQ-013 Port cfg_err  output  1  registered flag for a rejected configuration.

Function
REQ-014 The block SHALL implement two states, IDLE and RUN.
REQ-015 A configuration SHALL be valid iff P is even, 4 <= P <= 2^PRESCALE_W-2, and F >= 2.
REQ-016 In IDLE, edge_count and bit_count SHALL be held at 0.
REQ-017 IDLE with counter_enable=1 and a valid configuration SHALL latch P and F, clear cfg_err, and enter RUN; the first RUN cycle shows edge_count=0, bit_count=0.
REQ-018 IDLE with counter_enable=1 and an invalid configuration SHALL set cfg_err on the next clock and remain in IDLE.
REQ-019 cfg_err SHALL stay set until counter_enable=0 or a valid start occurs.
REQ-020 In RUN with counter_enable=1, edge_count SHALL increment by 1 per clock and wrap to 0 after the latched value P-1.
REQ-021 bit_done SHALL equal (RUN & counter_enable & edge_count==P-1); on that same clock bit_count SHALL increment.
REQ-022 frame_done SHALL equal (bit_done & bit_count==F-1); that clock SHALL clear both counters and return to IDLE.
REQ-023 frame_done SHALL occur exactly P*F clocks after RUN entry.
REQ-024 sample_strobe SHALL be asserted only in RUN with counter_enable=1, at the edge indices defined under Configuration, where mid = P/2.
REQ-025 counter_enable=0 in RUN SHALL abort the frame: next clock IDLE, counters 0, no bit_done or frame_done on the abort cycle.
REQ-026 Changes to prescale or frame_bits during RUN SHALL be ignored until the next IDLE-to-RUN transition.
REQ-027 counter_enable held high after frame_done SHALL start the next frame on the following clock, with a one-cycle IDLE gap.
REQ-028 All pulse outputs SHALL be decoded from registered state only, with no combinational path from prescale or frame_bits.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, edge_count=0, bit_count=0, cfg_err=0, and the latched P/F registers to 0, independent of clk.
REQ-030 During reset, sample_strobe, bit_done and frame_done SHALL read 0.
REQ-031 Deassertion of reset mid-frame SHALL resume in IDLE; no partial frame is continued.

Configuration
REQ-032 Macro UART_RX_OVERSAMPLE3_EN defined: sample_strobe SHALL pulse at edge_count = mid-1, mid and mid+1 (three samples per bit, for majority voting).
REQ-033 Macro UART_RX_OVERSAMPLE3_EN undefined: sample_strobe SHALL pulse only at edge_count = mid (one sample per bit).

Verification
REQ-034 P=8, F=10, enable held high -> edge_count cycles 0..7; bit_done every 8 clocks; frame_done 80 clocks after RUN entry; IDLE for 1 clock, then restart.
REQ-035 P=6, F=2 -> strobes at edge 2,3,4 with the macro defined; strobe at edge 3 only without it; frame_done after 12 clocks.
REQ-036 P=7, or P=2, or F=1, with enable=1 -> cfg_err=1 next clock, counters stay 0; drop enable -> cfg_err=0.
REQ-037 P=16, F=11, enable dropped at bit_count=3, edge_count=5 -> next clock IDLE, counters 0, no frame_done pulse.
REQ-038 P=8 latched, prescale changed to 16 at bit 2 -> bit period remains 8 for the whole frame; next frame uses 16.
REQ-039 rst asserted between clock edges mid-frame -> outputs zero immediately; after release, enable restarts a clean frame from edge 0, bit 0.

Source files
------------

// File: rtl/uart_rx_timing_counter.sv
// uart_rx_timing_counter: bit/frame timing generator for an oversampling UART
// receiver. Counts clocks within each bit (edge_count) and bits within each
// frame (bit_count), and decodes mid-bit sample, bit-done and frame-done pulses.
// Optional feature: define UART_RX_OVERSAMPLE3_EN for three mid-bit samples
// (majority voting); default build emits a single sample at mid-bit.
module uart_rx_timing_counter #(
   parameter int unsigned PRESCALE_W = 6,
   parameter int unsigned BIT_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [BIT_CNT_W-1:0]  frame_bits,
   input  logic                  counter_enable,
   output logic [PRESCALE_W-1:0] edge_count,
   output logic [BIT_CNT_W-1:0]  bit_count,
   output logic                  sample_strobe,
   output logic                  bit_done,
   output logic                  frame_done,
   output logic                  cfg_err
);

   localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
   localparam logic [PRESCALE_W-1:0] P_MAX = {{(PRESCALE_W-1){1'b1}}, 1'b0};
   localparam logic [BIT_CNT_W-1:0]  F_MIN = BIT_CNT_W'(2);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                r_state;
   logic [PRESCALE_W-1:0] r_edge;
   logic [BIT_CNT_W-1:0]  r_bit;
   logic [PRESCALE_W-1:0] r_p;
   logic [BIT_CNT_W-1:0]  r_f;
   logic                  r_cfg_err;

   logic                  w_cfg_valid;
   logic                  w_run_en;
   logic                  w_last_edge;
   logic                  w_last_bit;
   logic [PRESCALE_W-1:0] w_mid;
   logic                  w_bit_done;
   logic                  w_frame_done;
   logic                  w_strobe;

   // Start-time configuration check on the live inputs (only consulted in IDLE)
   assign w_cfg_valid = ~prescale[0] && (prescale >= P_MIN) && (prescale <= P_MAX)
                        && (frame_bits >= F_MIN);

   // Pulse decode from registered state and latched configuration only
   assign w_run_en     = (r_state == ST_RUN) && counter_enable;
   assign w_last_edge  = (r_edge == (r_p - PRESCALE_W'(1)));
   assign w_last_bit   = (r_bit == (r_f - BIT_CNT_W'(1)));
   assign w_mid        = r_p >> 1;
   assign w_bit_done   = w_run_en && w_last_edge;
   assign w_frame_done = w_bit_done && w_last_bit;

`ifdef UART_RX_OVERSAMPLE3_EN
   // Three samples centred on mid-bit; P >= 4 keeps mid-1 and mid+1 in range
   assign w_strobe = w_run_en && ((r_edge == (w_mid - PRESCALE_W'(1))) ||
                                  (r_edge == w_mid) ||
                                  (r_edge == (w_mid + PRESCALE_W'(1))));
`else
   // Single sample at mid-bit
   assign w_strobe = w_run_en && (r_edge == w_mid);
`endif

   assign edge_count    = r_edge;
   assign bit_count     = r_bit;
   assign sample_strobe = w_strobe;
   assign bit_done      = w_bit_done;
   assign frame_done    = w_frame_done;
   assign cfg_err       = r_cfg_err;

   // IDLE/RUN state machine with edge/bit counters and config latch
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_edge    <= '0;
         r_bit     <= '0;
         r_p       <= '0;
         r_f       <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_edge <= '0;
               r_bit  <= '0;
               if (counter_enable) begin
                  if (w_cfg_valid) begin
                     r_p       <= prescale;
                     r_f       <= frame_bits;
                     r_cfg_err <= 1'b0;
                     r_state   <= ST_RUN;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end else begin
                  r_cfg_err <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!counter_enable || w_frame_done) begin
                  // Abort or frame complete: one IDLE cycle before any restart
                  r_state <= ST_IDLE;
                  r_edge  <= '0;
                  r_bit   <= '0;
               end else if (w_bit_done) begin
                  r_edge <= '0;
                  r_bit  <= r_bit + BIT_CNT_W'(1);
               end else begin
                  r_edge <= r_edge + PRESCALE_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_edge  <= '0;
               r_bit   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_timing_counter.sv
// Testbench for uart_rx_timing_counter. Reference model tracks a frame as a
// single linear clock index n since RUN entry: edge = n % P, bit = n / P.
// Honors UART_RX_OVERSAMPLE3_EN the same way as the design.
module tb_uart_rx_timing_counter;

   localparam int PW = 6;
   localparam int BW = 4;
`ifdef UART_RX_OVERSAMPLE3_EN
   localparam int OS_HALF = 1;
`else
   localparam int OS_HALF = 0;
`endif

   logic          clk;
   logic          rst;
   logic [PW-1:0] prescale;
   logic [BW-1:0] frame_bits;
   logic          counter_enable;
   logic [PW-1:0] edge_count;
   logic [BW-1:0] bit_count;
   logic          sample_strobe;
   logic          bit_done;
   logic          frame_done;
   logic          cfg_err;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit m_run = 0;
   bit m_err = 0;
   int m_n   = 0;
   int m_p   = 0;
   int m_f   = 0;

   // Expected outputs for the current cycle
   int e_edge, e_bit;
   bit e_st, e_bd, e_fd, e_err;

   uart_rx_timing_counter #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
      .clk            (clk),
      .rst            (rst),
      .prescale       (prescale),
      .frame_bits     (frame_bits),
      .counter_enable (counter_enable),
      .edge_count     (edge_count),
      .bit_count      (bit_count),
      .sample_strobe  (sample_strobe),
      .bit_done       (bit_done),
      .frame_done     (frame_done),
      .cfg_err        (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit cfg_ok(input int p, input int f);
      return (p % 2 == 0) && (p >= 4) && (p <= (1 << PW) - 2) && (f >= 2);
   endfunction

   function automatic void model_eval();
      e_edge = 0; e_bit = 0; e_st = 0; e_bd = 0; e_fd = 0;
      e_err  = rst ? m_err : 1'b0;
      if (rst && m_run) begin
         e_edge = m_n % m_p;
         e_bit  = m_n / m_p;
         if (counter_enable) begin
            e_bd = (e_edge == m_p - 1);
            e_fd = (m_n == m_p * m_f - 1);
            e_st = (e_edge >= m_p / 2 - OS_HALF) && (e_edge <= m_p / 2 + OS_HALF);
         end
      end
   endfunction

   function automatic void model_update();
      if (!rst) begin
         m_run = 0; m_err = 0; m_n = 0;
      end else if (!m_run) begin
         if (counter_enable) begin
            if (cfg_ok(int'(prescale), int'(frame_bits))) begin
               m_run = 1; m_n = 0; m_p = int'(prescale); m_f = int'(frame_bits); m_err = 0;
            end else begin
               m_err = 1;
            end
         end else begin
            m_err = 0;
         end
      end else begin
         if (!counter_enable || (m_n == m_p * m_f - 1)) m_run = 0;
         else m_n++;
      end
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; counter_enable = 1'b0; prescale = 6'd8; frame_bits = 4'd10;
      #12;
      checks++; if (edge_count !== '0) begin failures++; $display("FAIL reset edge_count got=%0d exp=0", edge_count); end
      checks++; if (bit_count !== '0) begin failures++; $display("FAIL reset bit_count got=%0d exp=0", bit_count); end
      checks++; if (sample_strobe !== 1'b0) begin failures++; $display("FAIL reset sample_strobe got=%b exp=0", sample_strobe); end
      checks++; if (bit_done !== 1'b0) begin failures++; $display("FAIL reset bit_done got=%b exp=0", bit_done); end
      checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b exp=0", frame_done); end
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset cfg_err got=%b exp=0", cfg_err); end
      counter_enable = 1'b1;
      @(posedge clk); #1;
      checks++; if (edge_count !== '0 || cfg_err !== 1'b0) begin failures++; $display("FAIL reset_hold edge=%0d cfg_err=%b exp 0/0", edge_count, cfg_err); end
      counter_enable = 1'b0;
      @(negedge clk); rst = 1'b1;
      next_cycle();
   endtask

   task automatic test_frame_p8();
      int fd_idx[$];
      int bd_n = 0;
      int a, b;
      prescale = 6'd8; frame_bits = 4'd10; counter_enable = 1'b1;
      for (int i = 0; i < 170; i++) begin
         @(negedge clk); model_eval();
         checks++; if (edge_count !== PW'(e_edge)) begin failures++; $display("FAIL p8 edge_count cyc=%0d got=%0d exp=%0d", i, edge_count, e_edge); end
         checks++; if (bit_count !== BW'(e_bit)) begin failures++; $display("FAIL p8 bit_count cyc=%0d got=%0d exp=%0d", i, bit_count, e_bit); end
         checks++; if (bit_done !== e_bd) begin failures++; $display("FAIL p8 bit_done cyc=%0d got=%b exp=%b", i, bit_done, e_bd); end
         checks++; if (frame_done !== e_fd) begin failures++; $display("FAIL p8 frame_done cyc=%0d got=%b exp=%b", i, frame_done, e_fd); end
         if (frame_done === 1'b1) fd_idx.push_back(i);
         if (bit_done === 1'b1 && i <= 80) bd_n++;
         next_cycle();
      end
      a = (fd_idx.size() > 0) ? fd_idx[0] : -1;
      b = (fd_idx.size() > 1) ? fd_idx[1] : -1;
      checks++; if (a != 80) begin failures++; $display("FAIL p8 first_frame_done got=%0d exp=80", a); end
      checks++; if (b != 161) begin failures++; $display("FAIL p8 restart_frame_done got=%0d exp=161", b); end
      checks++; if (bd_n != 10) begin failures++; $display("FAIL p8 bit_done_count got=%0d exp=10", bd_n); end
      counter_enable = 1'b0;
      next_cycle(); next_cycle();
   endtask

   task automatic test_p6_f2();
      int got[$];
      int exp_q[$];
      int fd_at = -1;
      prescale = 6'd6; frame_bits = 4'd2; counter_enable = 1'b1;
      for (int b = 0; b < 2; b++)
         for (int e = 3 - OS_HALF; e <= 3 + OS_HALF; e++) exp_q.push_back(e);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk); model_eval();
         checks++; if (sample_strobe !== e_st) begin failures++; $display("FAIL p6 sample_strobe cyc=%0d got=%b exp=%b", i, sample_strobe, e_st); end
         if (sample_strobe === 1'b1 && fd_at < 0) got.push_back(int'(edge_count));
         if (frame_done === 1'b1 && fd_at < 0) fd_at = i;
         next_cycle();
      end
      checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL p6 strobe_count got=%0d exp=%0d", got.size(), exp_q.size()); end
      else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            checks++; if (got[k] != exp_q[k]) begin failures++; $display("FAIL p6 strobe_edge k=%0d got=%0d exp=%0d", k, got[k], exp_q[k]); end
         end
      end
      checks++; if (fd_at != 12) begin failures++; $display("FAIL p6 frame_done_at got=%0d exp=12", fd_at); end
      counter_enable = 1'b0;
      next_cycle(); next_cycle();
   endtask

   task automatic test_cfg_err();
      int bad_p[3] = '{7, 2, 8};
      int bad_f[3] = '{10, 10, 1};
      for (int k = 0; k < 3; k++) begin
         prescale = PW'(bad_p[k]); frame_bits = BW'(bad_f[k]); counter_enable = 1'b1;
         @(negedge clk);
         checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_pre k=%0d got=%b exp=0", k, cfg_err); end
         next_cycle(); @(negedge clk);
         checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_set k=%0d got=%b exp=1", k, cfg_err); end
         checks++; if (edge_count !== '0 || bit_count !== '0) begin failures++; $display("FAIL cfg_cnt k=%0d edge=%0d bit=%0d exp 0/0", k, edge_count, bit_count); end
         next_cycle(); @(negedge clk);
         checks++; if (cfg_err !== 1'b1 || bit_done !== 1'b0) begin failures++; $display("FAIL cfg_hold k=%0d cfg_err=%b bit_done=%b exp 1/0", k, cfg_err, bit_done); end
         counter_enable = 1'b0;
         next_cycle(); @(negedge clk);
         checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_clr k=%0d got=%b exp=0", k, cfg_err); end
         next_cycle();
      end
      prescale = 6'd9; frame_bits = 4'd4; counter_enable = 1'b1;
      next_cycle(); @(negedge clk);
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_set2 got=%b exp=1", cfg_err); end
      prescale = 6'd8;
      next_cycle(); @(negedge clk);
      checks++; if (cfg_err !== 1'b0 || edge_count !== '0) begin failures++; $display("FAIL cfg_valid_clr cfg_err=%b edge=%0d exp 0/0", cfg_err, edge_count); end
      next_cycle(); @(negedge clk);
      checks++; if (edge_count !== 6'd1) begin failures++; $display("FAIL cfg_run edge_count got=%0d exp=1", edge_count); end
      counter_enable = 1'b0;
      next_cycle(); next_cycle();
   endtask

   task automatic test_abort();
      bit found = 0;
      prescale = 6'd16; frame_bits = 4'd11; counter_enable = 1'b1;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (bit_count === 4'd3 && edge_count === 6'd5) found = 1;
         else next_cycle();
      end
      checks++;
      if (!found) begin
         failures++; $display("FAIL abort_reach got=timeout exp=bit3_edge5");
      end else begin
         counter_enable = 1'b0; #1;
         checks++; if (bit_done !== 1'b0 || frame_done !== 1'b0 || sample_strobe !== 1'b0) begin failures++; $display("FAIL abort_pulses bd=%b fd=%b st=%b exp 0/0/0", bit_done, frame_done, sample_strobe); end
         next_cycle(); @(negedge clk);
         checks++; if (edge_count !== '0 || bit_count !== '0) begin failures++; $display("FAIL abort_idle edge=%0d bit=%0d exp 0/0", edge_count, bit_count); end
         checks++; if (frame_done !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL abort_flags fd=%b cfg_err=%b exp 0/0", frame_done, cfg_err); end
      end
      counter_enable = 1'b0;
      next_cycle(); next_cycle();
   endtask

   task automatic test_cfg_change();
      int fd_idx[$];
      int bd_first = 0;
      int a, b;
      bit changed = 0;
      prescale = 6'd8; frame_bits = 4'd4; counter_enable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); model_eval();
         checks++; if (edge_count !== PW'(e_edge)) begin failures++; $display("FAIL chg edge_count cyc=%0d got=%0d exp=%0d", i, edge_count, e_edge); end
         checks++; if (bit_done !== e_bd) begin failures++; $display("FAIL chg bit_done cyc=%0d got=%b exp=%b", i, bit_done, e_bd); end
         if (frame_done === 1'b1) fd_idx.push_back(i);
         if (bit_done === 1'b1 && i <= 32) bd_first++;
         if (!changed && bit_count === 4'd2) begin prescale = 6'd16; changed = 1; end
         next_cycle();
      end
      a = (fd_idx.size() > 0) ? fd_idx[0] : -1;
      b = (fd_idx.size() > 1) ? fd_idx[1] : -1;
      checks++; if (a != 32) begin failures++; $display("FAIL chg first_frame_done got=%0d exp=32", a); end
      checks++; if (b != 97) begin failures++; $display("FAIL chg second_frame_done got=%0d exp=97", b); end
      checks++; if (bd_first != 4) begin failures++; $display("FAIL chg bit_done_count got=%0d exp=4", bd_first); end
      counter_enable = 1'b0;
      next_cycle(); next_cycle();
   endtask

   task automatic test_async_reset();
      int fdj = -1;
      prescale = 6'd8; frame_bits = 4'd10; counter_enable = 1'b1;
      for (int i = 0; i < 25; i++) next_cycle();
      #2;
      rst = 1'b0; m_run = 0; m_err = 0; m_n = 0;
      #1;
      checks++; if (edge_count !== '0 || bit_count !== '0) begin failures++; $display("FAIL arst_cnt edge=%0d bit=%0d exp 0/0", edge_count, bit_count); end
      checks++; if (sample_strobe !== 1'b0 || bit_done !== 1'b0 || frame_done !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL arst_pulses st=%b bd=%b fd=%b err=%b exp 0", sample_strobe, bit_done, frame_done, cfg_err); end
      next_cycle();
      @(negedge clk); rst = 1'b1;
      checks++; if (edge_count !== '0 || bit_count !== '0) begin failures++; $display("FAIL arst_release edge=%0d bit=%0d exp 0/0", edge_count, bit_count); end
      next_cycle(); @(negedge clk);
      checks++; if (edge_count !== '0 || bit_count !== '0) begin failures++; $display("FAIL arst_first_run edge=%0d bit=%0d exp 0/0", edge_count, bit_count); end
      for (int j = 0; j < 100; j++) begin
         if (j > 0) begin next_cycle(); @(negedge clk); end
         if (frame_done === 1'b1) begin fdj = j; break; end
      end
      checks++; if (fdj != 79) begin failures++; $display("FAIL arst_frame_done got=%0d exp=79", fdj); end
      counter_enable = 1'b0;
      next_cycle(); next_cycle();
   endtask

   task automatic test_random();
      int p, f, hold, gap;
      for (int it = 0; it < 25; it++) begin
         p = ($urandom_range(0, 9) < 8) ? 2 * int'($urandom_range(2, 10)) : int'($urandom_range(0, 63));
         f = ($urandom_range(0, 9) < 8) ? int'($urandom_range(2, 15)) : int'($urandom_range(0, 1));
         hold = int'($urandom_range(1, p * f + 4));
         gap  = int'($urandom_range(1, 2));
         prescale = PW'(p); frame_bits = BW'(f); counter_enable = 1'b1;
         for (int c = 0; c < hold + gap; c++) begin
            if (c == hold) counter_enable = 1'b0;
            @(negedge clk); model_eval();
            checks++; if (edge_count !== PW'(e_edge)) begin failures++; $display("FAIL rand edge_count it=%0d got=%0d exp=%0d", it, edge_count, e_edge); end
            checks++; if (bit_count !== BW'(e_bit)) begin failures++; $display("FAIL rand bit_count it=%0d got=%0d exp=%0d", it, bit_count, e_bit); end
            checks++; if (sample_strobe !== e_st) begin failures++; $display("FAIL rand sample_strobe it=%0d got=%b exp=%b", it, sample_strobe, e_st); end
            checks++; if (bit_done !== e_bd) begin failures++; $display("FAIL rand bit_done it=%0d got=%b exp=%b", it, bit_done, e_bd); end
            checks++; if (frame_done !== e_fd) begin failures++; $display("FAIL rand frame_done it=%0d got=%b exp=%b", it, frame_done, e_fd); end
            checks++; if (cfg_err !== e_err) begin failures++; $display("FAIL rand cfg_err it=%0d got=%b exp=%b", it, cfg_err, e_err); end
            if ($urandom_range(0, 15) == 0) begin
               prescale   = PW'($urandom_range(0, 63));
               frame_bits = BW'($urandom_range(0, 15));
            end
            next_cycle();
         end
      end
      counter_enable = 1'b0;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_frame_p8();
      test_p6_f2();
      test_cfg_err();
      test_abort();
      test_cfg_change();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
